// File: rtl/tmr_pkg.sv
// Shared types and constants for the timer configuration/halt sequencer.
package tmr_pkg;

  localparam int DIV_VAL_W = 4;
  localparam logic [DIV_VAL_W-1:0] DIV_VAL_MAX = 4'd8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND    = 2'd1,
    HALTING = 2'd2,
    HALTED  = 2'd3
  } tmr_state_e;

  // A divider code is usable only up to DIV_VAL_MAX; larger codes are rejected.
  function automatic logic div_val_legal(input logic [DIV_VAL_W-1:0] val);
    return (val <= DIV_VAL_MAX);
  endfunction

endpackage

// File: rtl/tmr_tmo_cnt.sv
// Saturating wait counter: flags when a pending update or halt has waited
// long enough that the next cycle must be treated as a boundary.
module tmr_tmo_cnt #(
  parameter int TMO_CYC = 512
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic hit
);

  localparam int CNT_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TMO_CYC - 1);

  logic [CNT_W-1:0] r_cnt;

  // Count waiting cycles, restart on clr, stick at the limit instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (run && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // A stale count outside a wait episode must never create a boundary.
  assign hit = run && (r_cnt == CNT_MAX);

endmodule

// File: rtl/tmr_cfg_seq.sv
// Divider-config shadowing and halt handshake for the timer prescaler path.
// Divider writes and halts only take effect on a clean tick boundary.
module tmr_cfg_seq
  import tmr_pkg::*;
#(
  parameter int TMO_CYC = 512
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 timer_en,
  input  logic                 cfg_wr,
  input  logic                 cfg_div_en,
  input  logic [DIV_VAL_W-1:0] cfg_div_val,
  input  logic                 err_clr,
  input  logic                 halt_req,
  input  logic                 debug_mode,
  input  logic                 cnt_en,
  output logic                 div_en,
  output logic [DIV_VAL_W-1:0] div_val,
  output logic                 cnt_halt,
  output logic                 halt_ack,
  output logic                 cfg_busy,
  output logic                 cfg_err
);

  tmr_state_e           r_state;
  tmr_state_e           w_state_nx;
  logic                 r_shd_en;
  logic [DIV_VAL_W-1:0] r_shd_val;
  logic                 r_div_en;
  logic [DIV_VAL_W-1:0] r_div_val;
  logic                 r_cnt_halt;
  logic                 r_halt_ack;
  logic                 r_cfg_busy;   // doubles as the "update pending" flag
  logic                 r_cfg_err;

  logic w_halt_src;
  logic w_wr_ok;
  logic w_wr_bad;
  logic w_safe;
  logic w_apply;
  logic w_pend_nx;
  logic w_want;
  logic w_tmo_run;
  logic w_tmo_clr;
  logic w_tmo_hit;

  assign w_halt_src = halt_req | debug_mode;
  assign w_wr_ok    = cfg_wr & div_val_legal(cfg_div_val);
  assign w_wr_bad   = cfg_wr & ~div_val_legal(cfg_div_val);
  assign w_safe     = cnt_en | ~timer_en | ~r_div_en | w_tmo_hit;
  // Update wanted this cycle: either still pending or freshly written.
  assign w_want     = r_cfg_busy | w_wr_ok;

  assign w_tmo_run  = (r_state == PEND) || (r_state == HALTING);
  // Restart the wait on a fresh episode; PEND->HALTING keeps the running wait.
  assign w_tmo_clr  = ((w_state_nx == PEND) && (r_state != PEND)) ||
                      ((w_state_nx == HALTING) && (r_state != HALTING) &&
                       (r_state != PEND));

  tmr_tmo_cnt #(.TMO_CYC(TMO_CYC)) u_tmo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_tmo_clr),
    .run   (w_tmo_run),
    .hit   (w_tmo_hit)
  );

  // Next state, apply decision and next pending flag.
  always_comb begin
    w_state_nx = r_state;
    w_apply    = 1'b0;
    w_pend_nx  = 1'b0;
    case (r_state)
      IDLE, PEND, HALTING: begin
        if (w_halt_src) begin
          if (w_safe) begin
            w_apply    = w_want;
            w_state_nx = HALTED;
          end else begin
            w_pend_nx  = w_want;
            w_state_nx = HALTING;
          end
        end else if (w_want && w_safe) begin
          w_apply    = 1'b1;
          w_state_nx = IDLE;
        end else if (w_want) begin
          w_pend_nx  = 1'b1;
          w_state_nx = PEND;
        end else begin
          w_state_nx = IDLE;
        end
      end
      HALTED: begin
        w_apply    = w_wr_ok;
        w_state_nx = w_halt_src ? HALTED : IDLE;
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  // State and shadow register; the shadow always holds the latest legal write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_shd_en  <= 1'b0;
      r_shd_val <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_wr_ok) begin
        r_shd_en  <= cfg_div_en;
        r_shd_val <= cfg_div_val;
      end else begin
        r_shd_en  <= r_shd_en;
        r_shd_val <= r_shd_val;
      end
    end
  end

  // Applied divider: a write in the applying cycle goes straight through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_en  <= 1'b0;
      r_div_val <= '0;
    end else if (w_apply) begin
      r_div_en  <= w_wr_ok ? cfg_div_en  : r_shd_en;
      r_div_val <= w_wr_ok ? cfg_div_val : r_shd_val;
    end else begin
      r_div_en  <= r_div_en;
      r_div_val <= r_div_val;
    end
  end

  // Handshake, busy and sticky error outputs; an illegal write beats err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_halt <= 1'b0;
      r_halt_ack <= 1'b0;
      r_cfg_busy <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_cnt_halt <= (w_state_nx == HALTED);
      r_halt_ack <= (w_state_nx == HALTED);
      r_cfg_busy <= w_pend_nx;
      if (w_wr_bad) begin
        r_cfg_err <= 1'b1;
      end else if (err_clr) begin
        r_cfg_err <= 1'b0;
      end else begin
        r_cfg_err <= r_cfg_err;
      end
    end
  end

  assign div_en   = r_div_en;
  assign div_val  = r_div_val;
  assign cnt_halt = r_cnt_halt;
  assign halt_ack = r_halt_ack;
  assign cfg_busy = r_cfg_busy;
  assign cfg_err  = r_cfg_err;

endmodule

// File: tb/tb_tmr_cfg_seq.sv
// Bench for tmr_cfg_seq: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the sequencer.
module tb_tmr_cfg_seq;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       timer_en, cfg_wr, cfg_div_en, err_clr, halt_req, debug_mode, cnt_en;
  logic [3:0] cfg_div_val;
  logic       div_en, cnt_halt, halt_ack, cfg_busy, cfg_err;
  logic [3:0] div_val;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // behavioural model state
  bit       md_en, m_sh_en, m_err, m_halted, m_halting, m_pend;
  bit [3:0] md_val, m_sh_val;
  int       m_wait;

  tmr_cfg_seq #(.TMO_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .timer_en(timer_en), .cfg_wr(cfg_wr),
    .cfg_div_en(cfg_div_en), .cfg_div_val(cfg_div_val), .err_clr(err_clr),
    .halt_req(halt_req), .debug_mode(debug_mode), .cnt_en(cnt_en),
    .div_en(div_en), .div_val(div_val), .cnt_halt(cnt_halt),
    .halt_ack(halt_ack), .cfg_busy(cfg_busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    md_en = 0; md_val = 0; m_sh_en = 0; m_sh_val = 0; m_err = 0;
    m_halted = 0; m_halting = 0; m_pend = 0; m_wait = 0;
  endtask

  // One clock of the rules: a boundary is a tick, a stopped timer, an
  // undivided path, or a wait that has lasted TMO cycles.
  task automatic m_step();
    bit halt, ok, bad, waiting, was_halting, safe, want, now_wait;
    halt = halt_req || debug_mode;
    ok   = cfg_wr && (cfg_div_val <= 4'd8);
    bad  = cfg_wr && (cfg_div_val > 4'd8);
    waiting     = m_pend || m_halting;
    was_halting = m_halting;
    safe = cnt_en || !timer_en || !md_en || (waiting && m_wait >= TMO - 1);
    if (ok) begin m_sh_en = cfg_div_en; m_sh_val = cfg_div_val; end
    if (bad) m_err = 1; else if (err_clr) m_err = 0;
    if (m_halted) begin
      if (ok) begin md_en = m_sh_en; md_val = m_sh_val; end
      if (!halt) m_halted = 0;
    end else begin
      want = m_pend || ok;
      if (halt && safe) begin
        if (want) begin md_en = m_sh_en; md_val = m_sh_val; end
        m_pend = 0; m_halting = 0; m_halted = 1;
      end else if (halt) begin
        m_pend = want; m_halting = 1;
      end else begin
        m_halting = 0;
        if (want && safe) begin md_en = m_sh_en; md_val = m_sh_val; m_pend = 0; end
        else m_pend = want;
      end
    end
    now_wait = m_pend || m_halting;
    if (now_wait && (!waiting || (was_halting && !m_halting))) m_wait = 0;
    else if (now_wait && m_wait < TMO - 1) m_wait = m_wait + 1;
  endtask

  task automatic cyc();
    m_step();
    @(posedge clk); #1;
    chk("m_div_en",   div_en,   md_en);
    chk("m_div_val",  div_val,  md_val);
    chk("m_cnt_halt", cnt_halt, m_halted);
    chk("m_halt_ack", halt_ack, m_halted);
    chk("m_cfg_busy", cfg_busy, m_pend);
    chk("m_cfg_err",  cfg_err,  m_err);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_div_en"},   div_en,   4'd0);
    chk({tag, "_div_val"},  div_val,  4'd0);
    chk({tag, "_cnt_halt"}, cnt_halt, 4'd0);
    chk({tag, "_halt_ack"}, halt_ack, 4'd0);
    chk({tag, "_busy"},     cfg_busy, 4'd0);
    chk({tag, "_err"},      cfg_err,  4'd0);
  endtask

  task automatic wr(input logic en, input logic [3:0] val);
    cfg_wr = 1'b1; cfg_div_en = en; cfg_div_val = val;
  endtask

  initial begin
    int per;
    rst_n = 1'b0; timer_en = 0; cfg_wr = 0; cfg_div_en = 0; cfg_div_val = 0;
    err_clr = 0; halt_req = 0; debug_mode = 0; cnt_en = 0;
    m_reset();
    #2 chk_zero("rst");
    @(posedge clk); #1 rst_n = 1'b1;

    // idle apply
    wr(1'b1, 4'd3); cyc(); cfg_wr = 0;
    chk("idle_div_en", div_en, 4'd1); chk("idle_div_val", div_val, 4'd3);
    chk("idle_busy", cfg_busy, 4'd0);

    // boundary apply
    wr(1'b1, 4'd2); cyc(); cfg_wr = 0;
    timer_en = 1; wr(1'b1, 4'd5); cyc(); cfg_wr = 0;
    chk("bnd_busy", cfg_busy, 4'd1); chk("bnd_old_val", div_val, 4'd2);
    for (int i = 0; i < 3; i++) begin cyc(); chk("bnd_busy_hold", cfg_busy, 4'd1); end
    cnt_en = 1; cyc(); cnt_en = 0;
    chk("bnd_new_val", div_val, 4'd5); chk("bnd_busy_fall", cfg_busy, 4'd0);

    // illegal write then clear
    wr(1'b1, 4'd9); cyc(); cfg_wr = 0;
    chk("ill_err", cfg_err, 4'd1); chk("ill_val", div_val, 4'd5);
    err_clr = 1; cyc(); err_clr = 0;
    chk("ill_clr", cfg_err, 4'd0);

    // halt handshake
    halt_req = 1; cyc(); chk("hlt_wait_ack", halt_ack, 4'd0);
    cyc(); chk("hlt_wait_ack2", halt_ack, 4'd0);
    cnt_en = 1; cyc(); cnt_en = 0;
    chk("hlt_ack", halt_ack, 4'd1); chk("hlt_cnt_halt", cnt_halt, 4'd1);
    halt_req = 0; cyc();
    chk("hlt_rel_ack", halt_ack, 4'd0); chk("hlt_rel_halt", cnt_halt, 4'd0);

    // timeout forces the update after TMO wait cycles
    wr(1'b1, 4'd7); cyc(); cfg_wr = 0;
    for (int i = 0; i < TMO - 1; i++) begin
      cyc(); chk("tmo_hold_val", div_val, 4'd5); chk("tmo_hold_busy", cfg_busy, 4'd1);
    end
    cyc(); chk("tmo_forced_val", div_val, 4'd7); chk("tmo_forced_busy", cfg_busy, 4'd0);

    // collision: write-through plus halt on the same boundary
    wr(1'b1, 4'd6); cyc(); cfg_wr = 0;
    chk("col_pend", cfg_busy, 4'd1);
    cnt_en = 1; halt_req = 1; wr(1'b1, 4'd4); cyc(); cnt_en = 0; cfg_wr = 0;
    chk("col_val", div_val, 4'd4); chk("col_ack", halt_ack, 4'd1);
    chk("col_busy", cfg_busy, 4'd0);
    cyc();
    rst_n = 1'b0; #2 chk_zero("rst_halted");
    m_reset(); halt_req = 0;
    @(posedge clk); #1 rst_n = 1'b1;

    // random traffic
    per = 4;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        case ($urandom_range(0, 3))
          0: per = 1;
          1: per = 4;
          2: per = 9;
          default: per = 40;
        endcase
      end
      cnt_en  = ($urandom_range(0, per - 1) == 0);
      if ($urandom_range(0, 99) == 0) timer_en = ~timer_en;
      if ($urandom_range(0, 29) == 0) halt_req = ~halt_req;
      if ($urandom_range(0, 59) == 0) debug_mode = ~debug_mode;
      err_clr = ($urandom_range(0, 19) == 0);
      cfg_wr  = ($urandom_range(0, 4) == 0);
      cfg_div_en  = ($urandom_range(0, 3) != 0);
      cfg_div_val = 4'($urandom_range(0, 11));
      if (i == 1500) begin
        rst_n = 1'b0; #2 chk_zero("rst_rand");
        m_reset();
        @(posedge clk); #1 rst_n = 1'b1;
      end
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
